mem_stage_dcache: RTL and testbench

MEM-stage block fed directly by the EX/MEM pipeline register. It consumes the latched ALU address, store data, memory control bits and branch flags, and serves loads and stores through a direct-mapped, write-through, no-write-allocate data cache backed by a single-beat memory handshake. While memory is busy it stalls the pipeline, and it resolves the taken-branch select for the fetch stage. Load data is returned toward the MEM/WB register.

---
 rtl/mem_stage_dcache.sv | 133 +++++++++++++
 tb/tb_mem_stage_dcache.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_dcache.sv
// MEM-stage data cache: direct-mapped, write-through, no-write-allocate, one word per line,
// backed by a single-beat memory handshake; also resolves the taken-branch select.
module mem_stage_dcache #(
  parameter int unsigned LINES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        branch,
  input  logic        zero_flag,
  output logic [31:0] rdata,
  output logic        dmem_stall,
  output logic        pc_src,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned TW = 30 - IW;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_MEM} state_t;

  state_t          state;
  logic [LINES-1:0] valid_q;
  logic [TW-1:0]   tag_q  [LINES];
  logic [31:0]     data_q [LINES];

  logic [IW-1:0] idx;
  logic [TW-1:0] tag;
  logic          hit;
  logic          is_store;
  logic          is_load;

  assign idx      = addr[2+IW-1:2];
  assign tag      = addr[31:2+IW];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);
  assign is_store = mem_write;
  assign is_load  = mem_read && !mem_write;

  // Byte offset bits are masked off: word-only access
  assign mem_addr  = addr & ~32'h0000_0003;
  assign mem_wdata = wdata;
  assign pc_src    = branch && zero_flag;

  // Outputs decoded from state and the current EX/MEM inputs
  always_comb begin
    rdata      = 32'd0;
    dmem_stall = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        if (is_store) begin
          dmem_stall = 1'b1;
        end else if (is_load) begin
          if (hit) rdata = data_q[idx];
          else     dmem_stall = 1'b1;
        end
      end
      RD_MISS: begin
        mem_req    = 1'b1;
        dmem_stall = !mem_ready;
        if (mem_ready) rdata = mem_rdata;
      end
      WR_MEM: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        dmem_stall = !mem_ready;
      end
      default: begin
        rdata      = 32'd0;
        dmem_stall = 1'b0;
      end
    endcase
  end

  // FSM, valid bits and saturating hit/miss counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      valid_q    <= '0;
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (is_store) begin
            state <= WR_MEM;
          end else if (is_load) begin
            if (hit) begin
              if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
            end else begin
              state <= RD_MISS;
              if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
            end
          end
        end
        RD_MISS: begin
          if (mem_ready) begin
            valid_q[idx] <= 1'b1;
            state        <= IDLE;
          end
        end
        WR_MEM: begin
          if (mem_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line payload: filled on read completion, updated on a store that hits
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == RD_MISS && mem_ready) begin
        tag_q[idx]  <= tag;
        data_q[idx] <= mem_rdata;
      end else if (state == WR_MEM && mem_ready && hit) begin
        data_q[idx] <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_dcache.sv
// Directed bench for mem_stage_dcache: miss/hit, write-through, no-allocate, aliasing, reset, branch.
module tb_mem_stage_dcache;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, branch, zero_flag, mem_ready;
  logic [31:0] addr, wdata, mem_rdata;
  logic [31:0] rdata, mem_addr, mem_wdata, hit_count, miss_count;
  logic        dmem_stall, pc_src, mem_req, mem_we;

  int checks   = 0;
  int failures = 0;

  mem_stage_dcache #(.LINES(64)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .branch(branch), .zero_flag(zero_flag),
    .rdata(rdata), .dmem_stall(dmem_stall), .pc_src(pc_src),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then driven and outputs sampled mid-cycle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Load miss with mem_ready in the cycle after the miss (k = 1)
  task automatic load_miss(input string tag, input logic [31:0] a, input logic [31:0] d);
    mem_read = 1'b1; addr = a;
    settle();
    chk({tag, "_stall0"}, 32'(dmem_stall), 32'd1);
    tick();
    mem_ready = 1'b1; mem_rdata = d;
    settle();
    chk({tag, "_req"}, 32'(mem_req), 32'd1);
    chk({tag, "_rdata"}, rdata, d);
    tick();
    mem_ready = 1'b0; mem_read = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = 32'd0; wdata = 32'd0;
    branch = 1'b0; zero_flag = 1'b0; mem_ready = 1'b0; mem_rdata = 32'd0;
    tick(); tick();
    rst = 1'b0;
    settle();
    chk("rst_req",   32'(mem_req),    32'd0);
    chk("rst_we",    32'(mem_we),     32'd0);
    chk("rst_stall", 32'(dmem_stall), 32'd0);
    chk("rst_rdata", rdata,           32'd0);
    chk("rst_hits",  hit_count,       32'd0);
    chk("rst_miss",  miss_count,      32'd0);

    // Load miss at 0x100, ready two cycles after the miss
    mem_read = 1'b1; addr = 32'h0000_0100;
    settle();
    chk("ld1_stall_c0", 32'(dmem_stall), 32'd1);
    chk("ld1_req_c0",   32'(mem_req),    32'd0);
    tick();
    settle();
    chk("ld1_stall_c1", 32'(dmem_stall), 32'd1);
    chk("ld1_req_c1",   32'(mem_req),    32'd1);
    chk("ld1_we_c1",    32'(mem_we),     32'd0);
    chk("ld1_addr",     mem_addr,        32'h0000_0100);
    tick();
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    settle();
    chk("ld1_stall_c2", 32'(dmem_stall), 32'd0);
    chk("ld1_rdata",    rdata,           32'hDEAD_BEEF);
    chk("ld1_miss",     miss_count,      32'd1);
    tick();
    mem_ready = 1'b0; mem_rdata = 32'd0;
    settle();
    chk("ld2_stall", 32'(dmem_stall), 32'd0);
    chk("ld2_rdata", rdata,           32'hDEAD_BEEF);
    chk("ld2_req",   32'(mem_req),    32'd0);
    tick();
    mem_read = 1'b0;
    settle();
    chk("ld2_hits",  hit_count,  32'd1);
    chk("ld2_miss",  miss_count, 32'd1);
    chk("idle_rdata", rdata,     32'd0);

    // Store hit at 0x100 updates the line (write-through)
    mem_write = 1'b1; addr = 32'h0000_0100; wdata = 32'h1234_5678;
    settle();
    chk("st1_stall_c0", 32'(dmem_stall), 32'd1);
    tick();
    mem_ready = 1'b1;
    settle();
    chk("st1_req",   32'(mem_req),    32'd1);
    chk("st1_we",    32'(mem_we),     32'd1);
    chk("st1_wdata", mem_wdata,       32'h1234_5678);
    chk("st1_stall", 32'(dmem_stall), 32'd0);
    tick();
    mem_ready = 1'b0; mem_write = 1'b0; mem_read = 1'b1;
    settle();
    chk("ld3_stall", 32'(dmem_stall), 32'd0);
    chk("ld3_rdata", rdata,           32'h1234_5678);
    tick();
    mem_read = 1'b0;
    settle();
    chk("ld3_hits", hit_count, 32'd2);

    // Store to uncached 0x200 with mem_read also high: store wins, no allocate, counters frozen
    mem_write = 1'b1; mem_read = 1'b1; addr = 32'h0000_0200; wdata = 32'hAAAA_5555;
    settle();
    chk("st2_stall_c0", 32'(dmem_stall), 32'd1);
    tick();
    mem_ready = 1'b1;
    settle();
    chk("st2_we", 32'(mem_we), 32'd1);
    tick();
    mem_ready = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
    settle();
    chk("st2_hits", hit_count,  32'd2);
    chk("st2_miss", miss_count, 32'd1);
    mem_read = 1'b1; addr = 32'h0000_0200;
    settle();
    chk("ld4_stall_c0", 32'(dmem_stall), 32'd1);
    tick();
    settle();
    chk("ld4_we",   32'(mem_we), 32'd0);
    chk("ld4_addr", mem_addr,    32'h0000_0200);
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    settle();
    chk("ld4_rdata", rdata, 32'hCAFE_F00D);
    tick();
    mem_ready = 1'b0; mem_read = 1'b0;
    settle();
    chk("ld4_miss", miss_count, 32'd2);

    // Stray mem_ready in IDLE is ignored
    mem_ready = 1'b1; mem_rdata = 32'h5A5A_5A5A;
    settle();
    chk("idle_rdy_rdata", rdata,           32'd0);
    chk("idle_rdy_stall", 32'(dmem_stall), 32'd0);
    tick();
    mem_ready = 1'b0;
    settle();
    chk("idle_rdy_req", 32'(mem_req), 32'd0);

    // Aliasing on index 0 from a clean cache: every load misses
    rst = 1'b1;
    tick();
    rst = 1'b0;
    load_miss("al1", 32'h0000_0100, 32'h1111_1111);
    load_miss("al2", 32'h0000_0200, 32'h2222_2222);
    load_miss("al3", 32'h0000_0100, 32'h3333_3333);
    settle();
    chk("al_miss", miss_count, 32'd3);
    chk("al_hits", hit_count,  32'd0);

    // Reset while in RD_MISS abandons the fill
    mem_read = 1'b1; addr = 32'h0000_0104;
    tick();
    settle();
    chk("rm_req_before", 32'(mem_req), 32'd1);
    rst = 1'b1; mem_read = 1'b0;
    tick();
    rst = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h7777_7777;
    settle();
    chk("rm_req_after", 32'(mem_req), 32'd0);
    chk("rm_rdata",     rdata,        32'd0);
    tick();
    mem_ready = 1'b0;
    load_miss("rm_ld", 32'h0000_0104, 32'h8888_8888);
    settle();
    chk("rm_miss", miss_count, 32'd1);

    // Branch select
    branch = 1'b1; zero_flag = 1'b1;
    settle();
    chk("br_taken",       32'(pc_src),     32'd1);
    chk("br_taken_stall", 32'(dmem_stall), 32'd0);
    zero_flag = 1'b0;
    settle();
    chk("br_nt",       32'(pc_src),     32'd0);
    chk("br_nt_stall", 32'(dmem_stall), 32'd0);
    branch = 1'b0; zero_flag = 1'b1;
    settle();
    chk("br_nobr", 32'(pc_src), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
